push_debounce: RTL and testbench
================================

// Module: push_debounce
// PURPOSE
//  Conditions raw board pushbuttons and the 4-bit switch bank ahead of the eq4 comparator.
//  - Synchronizes every button and switch input.
//  - Debounces each button independently with a per-button FSM and hold counter.
//  - Emits a clean level and a one-clock press pulse per button for eq4 push1/push2.
//  - Provides synchronized switch data, so eq4 'no' never sees metastable or bouncing inputs.
// PARAMETERS
//  NUM_BTN     2        number of independent pushbuttons (bit 0 -> push1, bit 1 -> push2)
//  SW_W        4        switch bank width (matches eq4 'no')
//  DB_CYCLES   500000   consecutive stable synchronized samples required to accept a new level
//  CNT_W       20       hold counter width; must satisfy 2**CNT_W > DB_CYCLES
// PORTS
//  clk        in   1        system clock; all logic is on its rising edge
//  rst_n      in   1        asynchronous reset, active low
//  btn_raw    in   NUM_BTN  raw bouncing buttons, active high
//  sw_raw     in   SW_W     raw switches
//  btn_level  out  NUM_BTN  debounced button level
//  btn_pulse  out  NUM_BTN  high for exactly 1 clk on each accepted press (0->1)
//  sw_sync    out  SW_W     switches after the 2-FF synchronizer
//  sw_snap    out  SW_W     sw_sync captured on the cycle any btn_pulse bit is high
// BEHAVIOUR
//  Reset (asynchronous assert, release on clk):
//  - All synchronizer flops, counters, btn_level, btn_pulse, sw_sync and sw_snap go to 0.
//  - Every button FSM goes to IDLE.
//  Synchronizer:
//  - Two flops per input bit.
//  - s = 2nd-stage value, 2 clk after the raw edge.
//  Per-button FSM, with hold counter cnt:
//  - IDLE: s=1 -> PRESS_WAIT with cnt=1.
//  - PRESS_WAIT:
//    - s=0 -> IDLE with cnt=0 (bounce, no output).
//    - s=1 and cnt==DB_CYCLES-1 -> PRESSED; btn_level<=1; btn_pulse<=1 for that one cycle.
//    - otherwise s=1 -> cnt++.
//  - PRESSED: s=0 -> RELEASE_WAIT with cnt=1.
//  - RELEASE_WAIT:
//    - s=1 -> PRESSED with cnt=0.
//    - s=0 and cnt==DB_CYCLES-1 -> IDLE; btn_level<=0.
//    - otherwise s=0 -> cnt++.
//  Latency: raw edge to btn_level/btn_pulse edge = 2 + DB_CYCLES clk when input is clean.
//  Pulses:
//  - btn_pulse is a registered output, never high on consecutive cycles.
//  - Holding a button does not repeat the pulse.
//  - Exactly one pulse per accepted press.
//  Simultaneous events:
//  - Buttons are fully independent; both btn_pulse bits may assert in the same cycle.
//  - sw_snap captures once, when any btn_pulse bit is high.
//  - sw_snap is registered: the value appears the cycle after the pulse, then holds until the next pulse.
//  Counter: cnt saturates by construction and never wraps; its value outside the WAIT states is don't-care.
//  Reset mid-debounce: the pending press is discarded; no pulse is emitted after rst_n deasserts.
//  - A button still held after reset completes a full DB_CYCLES qualification, then emits one pulse.
// CONFIGURATION
//  RELEASE_PULSE_EN defined:
//  - Adds output btn_rel_pulse [NUM_BTN], reset 0.
//  - It is high for 1 clk on the RELEASE_WAIT->IDLE transition.
//  - It does not affect sw_snap.
//  RELEASE_PULSE_EN undefined: port and logic are absent; all other behaviour is identical.
// TESTING (bench uses DB_CYCLES=4, CNT_W=3, clk period 20 ns)
//  T1 reset:
//  - Stimulus: rst_n=0 while btn_raw=2'b11, sw_raw=4'b1010.
//  - Response: all outputs 0.
//  - After release with buttons held: btn_pulse=2'b11 for exactly one cycle, 6 clk later.
//  T2 clean press:
//  - Stimulus: btn_raw[0] 0->1, held.
//  - Response: btn_pulse[0]=1 on clk 6 only; btn_level[0]=1 from clk 6; no further pulses while held.
//  T3 bounce reject:
//  - Stimulus: btn_raw[1] toggles 1,0,1,0 every clk for 8 clk, then stays 0.
//  - Response: btn_pulse[1] and btn_level[1] stay 0 throughout.
//  T4 snapshot:
//  - Stimulus: sw_raw=4'b1011, then press btn 0; sw_raw=4'b1010, then press btn 1.
//  - Response: sw_snap=1011 after the first pulse, 1010 after the second.
//  T5 simultaneous:
//  - Stimulus: both buttons rise on the same clk.
//  - Response: btn_pulse=2'b11 in one cycle; sw_snap updates once.
//  T6 reset mid-debounce:
//  - Stimulus: btn_raw[0]=1 for 3 clk, then rst_n low for 1 clk, then button released.
//  - Response: no pulse ever; with RELEASE_PULSE_EN, a full press/release gives btn_rel_pulse[0] for 1 clk, 6 clk after release.

Source files
------------

// File: rtl/push_debounce.sv
// Pushbutton/switch conditioner: 2-FF synchronizers, per-button debounce FSM, press pulse, switch snapshot.
// Optional feature: define RELEASE_PULSE_EN to add btn_rel_pulse (one-clock pulse on accepted release).
//
// state        | meaning
// ST_IDLE      | released level accepted, waiting for s=1
// ST_PRESS_WT  | s=1 seen, counting stable samples toward a press
// ST_PRESSED   | pressed level accepted, waiting for s=0
// ST_RELEASE_WT| s=0 seen, counting stable samples toward a release
module push_debounce #(
    parameter int NUM_BTN   = 2,
    parameter int SW_W      = 4,
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [SW_W-1:0]    sw_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [SW_W-1:0]    sw_sync,
    output logic [SW_W-1:0]    sw_snap
`ifdef RELEASE_PULSE_EN
    ,
    output logic [NUM_BTN-1:0] btn_rel_pulse
`endif
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRESS_WT   = 2'd1;
    localparam logic [1:0] ST_PRESSED    = 2'd2;
    localparam logic [1:0] ST_RELEASE_WT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_BTN-1:0] btn_s1_q, btn_s2_q;
    logic [SW_W-1:0]    sw_s1_q, sw_s2_q, sw_snap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            btn_s1_q <= btn_raw;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= sw_raw;
            sw_s2_q  <= sw_s1_q;
        end
    end

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        logic [1:0]       st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             lvl_q, lvl_d;
        logic             pls_q, pls_d;
        logic             s;
`ifdef RELEASE_PULSE_EN
        logic             rel_q, rel_d;
`endif

        assign s = btn_s2_q[b];

        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            lvl_d = lvl_q;
            pls_d = 1'b0;
`ifdef RELEASE_PULSE_EN
            rel_d = 1'b0;
`endif
            case (st_q)
                ST_IDLE: begin
                    if (s) begin
                        st_d  = ST_PRESS_WT;
                        cnt_d = CNT_ONE;
                    end
                end
                ST_PRESS_WT: begin
                    if (!s) begin
                        st_d  = ST_IDLE;
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        st_d  = ST_PRESSED;
                        lvl_d = 1'b1;
                        pls_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!s) begin
                        st_d  = ST_RELEASE_WT;
                        cnt_d = CNT_ONE;
                    end
                end
                ST_RELEASE_WT: begin
                    if (s) begin
                        st_d  = ST_PRESSED;
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        st_d  = ST_IDLE;
                        lvl_d = 1'b0;
`ifdef RELEASE_PULSE_EN
                        rel_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                    lvl_d = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q  <= ST_IDLE;
                cnt_q <= '0;
                lvl_q <= 1'b0;
                pls_q <= 1'b0;
`ifdef RELEASE_PULSE_EN
                rel_q <= 1'b0;
`endif
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
                pls_q <= pls_d;
`ifdef RELEASE_PULSE_EN
                rel_q <= rel_d;
`endif
            end
        end

        assign btn_level[b] = lvl_q;
        assign btn_pulse[b] = pls_q;
`ifdef RELEASE_PULSE_EN
        assign btn_rel_pulse[b] = rel_q;
`endif
    end

    // Snapshot follows the registered pulse, so the captured value lands one cycle after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_snap_q <= '0;
        end else if (|btn_pulse) begin
            sw_snap_q <= sw_s2_q;
        end
    end

    assign sw_sync = sw_s2_q;
    assign sw_snap = sw_snap_q;

endmodule

// File: tb/tb_push_debounce.sv
// Directed bench for push_debounce with DB_CYCLES=4, CNT_W=3, 20 ns clock.
module tb_push_debounce;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic [3:0] sw_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_pulse;
    logic [3:0] sw_sync;
    logic [3:0] sw_snap;
`ifdef RELEASE_PULSE_EN
    logic [1:0] btn_rel_pulse;
`endif

    int vecs = 0;
    int errs = 0;

    push_debounce #(
        .NUM_BTN  (2),
        .SW_W     (4),
        .DB_CYCLES(4),
        .CNT_W    (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .sw_raw   (sw_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .sw_sync  (sw_sync),
        .sw_snap  (sw_snap)
`ifdef RELEASE_PULSE_EN
        ,
        .btn_rel_pulse(btn_rel_pulse)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        sw_raw  = 4'b1010;

        // T1: reset with buttons held
        tick();
        tick();
        chk("t1_rst_level", 8'(btn_level), 8'h00);
        chk("t1_rst_pulse", 8'(btn_pulse), 8'h00);
        chk("t1_rst_sync",  8'(sw_sync),   8'h00);
        chk("t1_rst_snap",  8'(sw_snap),   8'h00);
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("t1_pulse_c%0d", i), 8'(btn_pulse), (i == 6) ? 8'h03 : 8'h00);
            chk($sformatf("t1_level_c%0d", i), 8'(btn_level), (i >= 6) ? 8'h03 : 8'h00);
            if (i == 2) chk("t1_sync", 8'(sw_sync), 8'h0a);
        end
        chk("t1_snap", 8'(sw_snap), 8'h0a);
        btn_raw = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("t1_rel_level_c%0d", i), 8'(btn_level), (i >= 6) ? 8'h00 : 8'h03);
`ifdef RELEASE_PULSE_EN
            chk($sformatf("t1_relp_c%0d", i), 8'(btn_rel_pulse), (i == 6) ? 8'h03 : 8'h00);
`endif
        end
        tick();
        tick();

        // T2: clean press on button 0, held
        btn_raw = 2'b01;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("t2_pulse_c%0d", i), 8'(btn_pulse), (i == 6) ? 8'h01 : 8'h00);
            chk($sformatf("t2_level_c%0d", i), 8'(btn_level), (i >= 6) ? 8'h01 : 8'h00);
        end
        btn_raw = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        chk("t2_released", 8'(btn_level), 8'h00);

        // T3: bouncing button 1 is rejected
        for (int i = 0; i < 8; i++) begin
            btn_raw = (i % 2 == 0) ? 2'b10 : 2'b00;
            tick();
            chk($sformatf("t3_pulse_c%0d", i), 8'(btn_pulse), 8'h00);
            chk($sformatf("t3_level_c%0d", i), 8'(btn_level), 8'h00);
        end
        btn_raw = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t3_quiet_c%0d", i), 8'({btn_pulse, btn_level}), 8'h00);
        end

        // T4: snapshot tracks switch value at each pulse
        sw_raw = 4'b1011;
        for (int i = 0; i < 3; i++) tick();
        btn_raw = 2'b01;
        for (int i = 0; i < 6; i++) tick();
        chk("t4_pulse0", 8'(btn_pulse), 8'h01);
        tick();
        chk("t4_snap0", 8'(sw_snap), 8'h0b);
        btn_raw = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        sw_raw = 4'b1010;
        for (int i = 0; i < 3; i++) tick();
        btn_raw = 2'b10;
        for (int i = 0; i < 6; i++) tick();
        chk("t4_pulse1", 8'(btn_pulse), 8'h02);
        chk("t4_snap_hold", 8'(sw_snap), 8'h0b);
        tick();
        chk("t4_snap1", 8'(sw_snap), 8'h0a);
        btn_raw = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        chk("t4_released", 8'(btn_level), 8'h00);

        // T5: simultaneous press
        sw_raw = 4'b0110;
        for (int i = 0; i < 3; i++) tick();
        btn_raw = 2'b11;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("t5_pulse_c%0d", i), 8'(btn_pulse), (i == 6) ? 8'h03 : 8'h00);
            if (i >= 7) chk($sformatf("t5_snap_c%0d", i), 8'(sw_snap), 8'h06);
            if (i <= 6) chk($sformatf("t5_snap_pre_c%0d", i), 8'(sw_snap), 8'h0a);
        end
        btn_raw = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        chk("t5_released", 8'(btn_level), 8'h00);

        // T6: reset in the middle of a press qualification
        btn_raw = 2'b01;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_all", 8'({btn_pulse, btn_level}), 8'h00);
        chk("t6_rst_snap", 8'(sw_snap), 8'h00);
        tick();
        rst_n   = 1'b1;
        btn_raw = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("t6_nopulse_c%0d", i), 8'({btn_pulse, btn_level}), 8'h00);
        end

        // Full press/release on button 0 after the aborted one
        btn_raw = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("t6_pulse_c%0d", i), 8'(btn_pulse), (i == 6) ? 8'h01 : 8'h00);
        end
        btn_raw = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("t6_level_c%0d", i), 8'(btn_level), (i >= 6) ? 8'h00 : 8'h01);
`ifdef RELEASE_PULSE_EN
            chk($sformatf("t6_relp_c%0d", i), 8'(btn_rel_pulse), (i == 6) ? 8'h01 : 8'h00);
`endif
        end
        chk("t6_snap_kept", 8'(sw_snap), 8'h06);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
